// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit: turns an Execute->Memory request into one
// variable-latency bus transaction, stalls the pipeline while it is outstanding,
// and returns the formatted load result during the single DONE cycle.
//
// state | meaning
// IDLE  | no transaction; a new aligned access launches on the next edge
// REQ   | bus request outstanding, waiting for mem_ready or the timeout
// DONE  | result valid on ReadDataM/BusErrM; pipeline advances on the next edge
module mem_stage_lsu #(
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [2:0]  Funct3M,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] ReadDataM,
  output logic        StallM,
  output logic        MisalignM,
  output logic        BusErrM,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

  // Timeout fires on the REQ cycle whose count equals MAX_WAIT-1, giving MAX_WAIT REQ cycles.
  localparam logic [7:0] LP_CNT_LAST = 8'(MAX_WAIT - 1);

  state_t      r_state;
  logic [7:0]  r_cnt;
  logic        r_we;
  logic [31:0] r_addr;
  logic [3:0]  r_be;
  logic [31:0] r_wdata;
  logic [2:0]  r_funct3;
  logic [1:0]  r_lo;
  logic [31:0] r_rdata;
  logic        r_err;

  logic        w_acc;
  logic [1:0]  w_size;     // 0 byte, 1 half, 2 word
  logic        w_mis;
  logic [3:0]  w_be_st;
  logic [31:0] w_wdata_st;
  logic [31:0] w_shift;
  logic [31:0] w_ld;

  // Decode access size and alignment, and lane-position store data.
  always_comb begin
    w_acc = MemReadM | MemWriteM;
    case (Funct3M)
      3'b000, 3'b100: w_size = 2'd0;
      3'b001, 3'b101: w_size = 2'd1;
      default:        w_size = 2'd2;
    endcase
    w_mis = ((w_size == 2'd1) && ALUResultM[0]) ||
            ((w_size == 2'd2) && (ALUResultM[1:0] != 2'b00));
    case (w_size)
      2'd0: begin
        w_be_st    = 4'b0001 << ALUResultM[1:0];
        w_wdata_st = {4{WriteDataM[7:0]}};
      end
      2'd1: begin
        w_be_st    = 4'b0011 << ALUResultM[1:0];
        w_wdata_st = {2{WriteDataM[15:0]}};
      end
      default: begin
        w_be_st    = 4'b1111;
        w_wdata_st = WriteDataM;
      end
    endcase
  end

  // Extract and extend the addressed byte/half of the returned bus word.
  always_comb begin
    w_shift = mem_rdata >> {r_lo, 3'b000};
    case (r_funct3)
      3'b000:  w_ld = {{24{w_shift[7]}}, w_shift[7:0]};
      3'b100:  w_ld = {24'd0, w_shift[7:0]};
      3'b001:  w_ld = {{16{w_shift[15]}}, w_shift[15:0]};
      3'b101:  w_ld = {16'd0, w_shift[15:0]};
      default: w_ld = mem_rdata;
    endcase
  end

  // Sequencer: launch, wait/timeout, present result for one cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_be     <= '0;
      r_wdata  <= '0;
      r_funct3 <= '0;
      r_lo     <= '0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_acc && !w_mis) begin
            r_we     <= MemWriteM;
            r_addr   <= {ALUResultM[31:2], 2'b00};
            r_be     <= MemWriteM ? w_be_st : 4'b1111;
            r_wdata  <= w_wdata_st;
            r_funct3 <= Funct3M;
            r_lo     <= ALUResultM[1:0];
            r_cnt    <= '0;
            r_state  <= S_REQ;
          end
        end
        S_REQ: begin
          if (mem_ready) begin
            r_rdata <= r_we ? 32'd0 : w_ld;
            r_err   <= 1'b0;
            r_state <= S_DONE;
          end else if (r_cnt == LP_CNT_LAST) begin
            r_rdata <= 32'd0;
            r_err   <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Pipeline-facing outputs; reset gates the combinational paths so they drop at once.
  always_comb begin
    StallM    = reset && (((r_state == S_IDLE) && w_acc && !w_mis) || (r_state == S_REQ));
    MisalignM = reset && (r_state == S_IDLE) && w_acc && w_mis;
    ReadDataM = (r_state == S_DONE) ? r_rdata : 32'd0;
    BusErrM   = (r_state == S_DONE) && r_err;
    mem_req   = (r_state == S_REQ);
    mem_we    = (r_state == S_REQ) && r_we;
    mem_addr  = r_addr;
    mem_wdata = r_wdata;
    mem_be    = r_be;
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
module tb_mem_stage_lsu;

  localparam int unsigned MW = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemReadM, MemWriteM;
  logic [2:0]  Funct3M;
  logic [31:0] ALUResultM, WriteDataM;
  logic [31:0] ReadDataM;
  logic        StallM, MisalignM, BusErrM;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  mem_stage_lsu #(.MAX_WAIT(MW)) dut (
    .clk(clk), .reset(reset),
    .MemReadM(MemReadM), .MemWriteM(MemWriteM), .Funct3M(Funct3M),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
    .ReadDataM(ReadDataM), .StallM(StallM), .MisalignM(MisalignM), .BusErrM(BusErrM),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        mis;
    int          stall;
    int          req;
    logic        we;
    logic [31:0] baddr;
    logic [31:0] bwdata;
    logic [3:0]  be;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   mon_en   = 1'b0;
  int   stall_cnt, req_cnt;
  int   plan_waits;
  logic [31:0] plan_rdata;
  int   rsp_cnt;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference model: derived from the access rules with plain arithmetic.
  function automatic exp_t model(bit wr, logic [2:0] f3, logic [31:0] addr,
                                 logic [31:0] wd, int waits, logic [31:0] word);
    exp_t e;
    int nb, off;
    bit sgn;
    longint v, span;
    case (f3)
      3'd0: begin nb = 1; sgn = 1; end
      3'd4: begin nb = 1; sgn = 0; end
      3'd1: begin nb = 2; sgn = 1; end
      3'd5: begin nb = 2; sgn = 0; end
      default: begin nb = 4; sgn = 0; end
    endcase
    off      = int'(addr % 4);
    e.mis    = (off % nb) != 0;
    e.we     = wr;
    e.baddr  = addr - 32'(off);
    e.be     = wr ? 4'(((1 << nb) - 1) << off) : 4'hF;
    if (nb == 1)      e.bwdata = (wd & 32'hFF) * 32'h0101_0101;
    else if (nb == 2) e.bwdata = (wd & 32'hFFFF) * 32'h0001_0001;
    else              e.bwdata = wd;
    e.err = 1'b0; e.rdata = 32'd0; e.stall = 0; e.req = 0;
    if (!e.mis) begin
      if (waits >= int'(MW)) begin
        e.err = 1'b1; e.stall = int'(MW) + 1; e.req = int'(MW);
      end else begin
        e.stall = waits + 2; e.req = waits + 1;
        if (!wr) begin
          span = longint'(1) << (8 * nb);
          v = (longint'(word) >> (8 * off)) % span;
          if (sgn && v >= span / 2) v = v - span;
          e.rdata = v[31:0];
        end
      end
    end
    return e;
  endfunction

  // Bus responder: mem_ready after plan_waits REQ cycles; noise outside REQ.
  initial begin
    mem_ready = 1'b0; mem_rdata = 32'd0; rsp_cnt = 0;
    forever begin
      @(posedge clk); #1;
      if (mem_req) begin
        mem_ready = (rsp_cnt == plan_waits);
        mem_rdata = plan_rdata;
        rsp_cnt++;
      end else begin
        rsp_cnt   = 0;
        mem_ready = 1'($urandom_range(1));
        mem_rdata = $urandom;
      end
    end
  end

  // Monitor: checks bus fields each REQ cycle and pops a result on completion.
  initial begin
    stall_cnt = 0; req_cnt = 0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (StallM) stall_cnt++;
        if (mem_req) begin
          req_cnt++;
          if (exp_q.size() == 0) check("req_without_txn", 32'd1, 32'd0);
          else begin
            check("mem_addr", mem_addr, exp_q[0].baddr);
            check("mem_be", 32'(mem_be), 32'(exp_q[0].be));
            check("mem_we", 32'(mem_we), 32'(exp_q[0].we));
            if (exp_q[0].we) check("mem_wdata", mem_wdata, exp_q[0].bwdata);
          end
        end
        if ((MemReadM || MemWriteM) && !StallM) begin
          if (exp_q.size() == 0) check("unexpected_completion", 32'd1, 32'd0);
          else begin
            exp_t e;
            e = exp_q.pop_front();
            check("ReadDataM", ReadDataM, e.rdata);
            check("BusErrM", 32'(BusErrM), 32'(e.err));
            check("MisalignM", 32'(MisalignM), 32'(e.mis));
            check("stall_cycles", 32'(stall_cnt), 32'(e.stall));
            check("req_cycles", 32'(req_cnt), 32'(e.req));
          end
          stall_cnt = 0; req_cnt = 0;
        end else if (!(MemReadM || MemWriteM)) begin
          check("idle_outputs", {ReadDataM[31:4], ReadDataM[3:0] | {StallM, MisalignM, BusErrM, mem_req}}, 32'd0);
        end
      end
    end
  end

  // Launch one access at posedge+1 (DUT in IDLE); returns at posedge+1 after completion.
  task automatic do_access(input bit rd, input bit wr, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wd,
                           input int waits, input logic [31:0] word);
    bit done = 0;
    exp_q.push_back(model(wr, f3, addr, wd, waits, word));
    plan_waits = waits; plan_rdata = word;
    MemReadM = rd; MemWriteM = wr; Funct3M = f3; ALUResultM = addr; WriteDataM = wd;
    for (int c = 0; c < 50 && !done; c++) begin
      @(negedge clk);
      if (!StallM) done = 1;
    end
    if (!done) begin
      check("completion_timeout", 32'd0, 32'd1);
      exp_q.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic go_idle(input int n);
    MemReadM = 0; MemWriteM = 0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    reset = 1'b0;
    MemReadM = 1'b1; MemWriteM = 1'b0; Funct3M = 3'b010;
    ALUResultM = 32'h6; WriteDataM = 32'd0;
    plan_waits = 0; plan_rdata = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_StallM", 32'(StallM), 32'd0);
    check("rst_MisalignM", 32'(MisalignM), 32'd0);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_ReadDataM", ReadDataM, 32'd0);
    check("rst_BusErrM", 32'(BusErrM), 32'd0);
    MemReadM = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    mon_en = 1'b1;

    do_access(1, 0, 3'b010, 32'h10, 32'd0, 0, 32'hDEAD_BEEF);
    do_access(1, 0, 3'b000, 32'h13, 32'd0, 0, 32'h80FF_0000);
    do_access(1, 0, 3'b100, 32'h13, 32'd0, 1, 32'h80FF_0000);
    do_access(0, 1, 3'b001, 32'h22, 32'h1234_ABCD, 3, 32'hFFFF_FFFF);
    do_access(1, 0, 3'b010, 32'h06, 32'd0, 0, 32'h1111_1111);
    do_access(1, 0, 3'b010, 32'h40, 32'd0, 10, 32'h2222_2222);
    go_idle(2);
    do_access(1, 1, 3'b000, 32'h41, 32'h0000_00A5, 2, 32'h3333_3333);
    do_access(1, 0, 3'b101, 32'h42, 32'd0, 3, 32'h8001_7FFF);

    for (int i = 0; i < 150; i++) begin
      int k;
      logic [31:0] a;
      k = int'($urandom_range(2));
      a = $urandom;
      if ($urandom_range(1) == 1) a[1:0] = 2'b00;
      do_access(k != 1, k != 0, 3'($urandom_range(7)), a, $urandom,
                int'($urandom_range(6)), $urandom);
      if ($urandom_range(3) == 0) go_idle(int'($urandom_range(1, 2)));
    end
    go_idle(2);

    // Reset pulsed in the second REQ cycle, then a normal load.
    mon_en = 1'b0;
    plan_waits = 10; plan_rdata = 32'h5555_5555;
    MemReadM = 1; MemWriteM = 0; Funct3M = 3'b010; ALUResultM = 32'h80;
    @(posedge clk); #1;
    @(posedge clk); #2;
    check("pre_rst_mem_req", 32'(mem_req), 32'd1);
    reset = 1'b0;
    #1;
    check("midrst_mem_req", 32'(mem_req), 32'd0);
    check("midrst_StallM", 32'(StallM), 32'd0);
    check("midrst_ReadDataM", ReadDataM, 32'd0);
    MemReadM = 0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    stall_cnt = 0; req_cnt = 0;
    mon_en = 1'b1;
    do_access(1, 0, 3'b010, 32'h84, 32'd0, 1, 32'hCAFE_F00D);
    go_idle(2);

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
- Load/store unit for the Memory stage of the 5-stage RISC-V pipeline.
- Consumes the Execute→Memory pipeline register outputs (address, store data, access size) and drives a variable-latency data-memory bus.
- Returns aligned, sign/zero-extended load data as ReadDataM to the Memory→Writeback register.
- Raises StallM to the hazard unit while a bus transaction is outstanding.

Parameters:
- MAX_WAIT, 255, maximum REQ-state cycles without mem_ready before the access is aborted with a bus error (1..255).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- MemReadM  in  1  load in Memory stage.
- MemWriteM  in  1  store in Memory stage; has priority if both MemReadM and MemWriteM are high.
- Funct3M  in  3  size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU; any other value is treated as W.
- ALUResultM  in  32  byte address.
- WriteDataM  in  32  store data, right-aligned.
- ReadDataM  out  32  formatted load result.
- StallM  out  1  hold F/D/E/M stages.
- MisalignM  out  1  misaligned access flag.
- BusErrM  out  1  timeout flag.
- mem_req  out  1  bus request.
- mem_we  out  1  bus write enable.
- mem_addr  out  32  word address {ALUResultM[31:2],2'b00}.
- mem_wdata  out  32  lane-positioned store data.
- mem_be  out  4  byte enables.
- mem_ready  in  1  bus completion.
- mem_rdata  in  32  bus read word.

Behaviour:
- FSM states: IDLE, REQ, DONE. Registers:
  - state
  - wait counter (8 bit)
  - latched we/addr/be/wdata
  - latched funct3 and addr[1:0]
  - rdata_q
  - err_q
- Reset (asserted low, any time, including mid-REQ):
  - state=IDLE; all registers zero.
  - mem_req=0, StallM=0, ReadDataM=0, MisalignM=0, BusErrM=0 immediately, without waiting for a clock edge.
- acc = MemReadM | MemWriteM.
- Misaligned: H/HU with addr[0]=1, or W with addr[1:0]≠00.
- IDLE:
  - If acc and misaligned: MisalignM=1 combinationally, StallM=0, no bus request, no store performed, ReadDataM=0, stay IDLE.
  - If acc and aligned: StallM=1; at the clock edge latch the request, clear the counter, go to REQ.
  - If no acc: outputs idle, ReadDataM=0.
- REQ:
  - mem_req=1; mem_we/addr/be/wdata come from the latched registers and are held stable until completion. StallM=1.
  - mem_ready=1 at an edge: capture formatted mem_rdata into rdata_q (stores capture 0), err_q=0, go to DONE.
  - Else counter++. When counter reaches MAX_WAIT-1 with no mem_ready: err_q=1, rdata_q=0, go to DONE.
- DONE:
  - mem_req=0, StallM=0, ReadDataM=rdata_q, BusErrM=err_q.
  - Next edge: go to IDLE (the pipeline advances on that same edge).
- mem_ready is ignored outside REQ.
- Minimum M-stage occupancy is 3 cycles (IDLE, REQ, DONE) with zero-wait memory. Each wait state adds 1 cycle.
- Store formatting:
  - B: mem_be=0001<<addr[1:0]; wdata = byte replicated ×4.
  - H: mem_be=0011<<addr[1:0]; wdata = half replicated ×2.
  - W: mem_be=1111.
- Load formatting:
  - Select the byte/half at addr[1:0] from mem_rdata.
  - B/H sign-extend; BU/HU zero-extend; W is unchanged.
- Loads drive mem_be=1111.

Test Plan:
- LW at 0x0000_0010, mem_rdata=0xDEADBEEF, mem_ready high in the first REQ cycle:
  - mem_req high for exactly 1 cycle, mem_addr=0x10, be=1111.
  - StallM high for 2 cycles; ReadDataM=0xDEADBEEF in DONE.
- LB at 0x0000_0013 and LBU at the same address, mem_rdata=0x80FF_0000 → ReadDataM=0xFFFFFF80 (LB), 0x00000080 (LBU).
- SH at 0x0000_0022, WriteDataM=0x1234_ABCD, 3 wait states:
  - mem_be=1100, mem_wdata=0xABCDABCD, mem_we=1.
  - Bus signals stable for 4 REQ cycles; StallM high for 5 cycles; ReadDataM=0.
- LW at 0x0000_0006 → MisalignM=1 in the same cycle, StallM=0, mem_req never asserted.
- MAX_WAIT=4, mem_ready held low → 4 REQ cycles, then DONE with BusErrM=1, ReadDataM=0, then IDLE.
- Reset pulsed low during the second REQ cycle:
  - mem_req and StallM drop before the next edge.
  - After release, a new LW completes normally with correct data.
